// File: rtl/sha256_msg_packer.sv
// Byte-stream to single-block SHA-256 message packer: collects up to 55 bytes, pads, emits 16 words.
// Optional overflow reporting and message discard is enabled by defining SHA256_PACKER_LEN_CHECK_EN.
module sha256_msg_packer #(
    parameter int HOLD_CYCLES = 3,
    parameter int MAX_BYTES   = 55
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    input  logic        rx_last,
    input  logic        core_dv_flag,
    output logic        MP_dv,
    output logic [31:0] message_out,
    output logic [4:0]  counter,
    output logic        busy,
    output logic        len_err
);

    typedef enum logic [1:0] {S_COLLECT, S_PAD, S_EMIT, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] buf_q [16];
    logic [31:0] buf_d [16];
    logic [5:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  hold_q, hold_d;
    logic [3:0]  word_idx_q, word_idx_d;
    logic [31:0] msg_q, msg_d;
    logic        seen_q, seen_d;
    logic        take_byte, go_pad, clear_buf, ovf;
    logic [1:0]  lane;
`ifdef SHA256_PACKER_LEN_CHECK_EN
    logic        drop_q, drop_d;
    logic        len_err_q, len_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        hold_d     = hold_q;
        word_idx_d = word_idx_q;
        msg_d      = msg_q;
        seen_d     = seen_q;
        take_byte  = 1'b0;
        go_pad     = 1'b0;
        clear_buf  = 1'b0;
        for (int i = 0; i < 16; i++) buf_d[i] = buf_q[i];
        ovf  = (byte_cnt_q == 6'(MAX_BYTES));
        // Byte 0 of each word is its most significant lane.
        lane = 2'd3 - byte_cnt_q[1:0];
`ifdef SHA256_PACKER_LEN_CHECK_EN
        drop_d    = drop_q;
        len_err_d = 1'b0;
`endif

        case (state_q)
            S_COLLECT: begin
                if (rx_dv) begin
`ifdef SHA256_PACKER_LEN_CHECK_EN
                    if (drop_q) begin
                        drop_d = !rx_last;
                    end else if (ovf) begin
                        len_err_d  = 1'b1;
                        drop_d     = !rx_last;
                        byte_cnt_d = '0;
                        clear_buf  = 1'b1;
                    end else begin
                        take_byte = 1'b1;
                        go_pad    = rx_last;
                    end
`else
                    // Overflow bytes are dropped but rx_last still closes the message.
                    take_byte = !ovf;
                    go_pad    = rx_last;
`endif
                end
                if (take_byte) begin
                    buf_d[byte_cnt_q[5:2]][{lane, 3'b000} +: 8] = rx_byte;
                    byte_cnt_d = byte_cnt_q + 6'd1;
                end
                if (go_pad) state_d = S_PAD;
            end
            S_PAD: begin
                buf_d[byte_cnt_q[5:2]][{lane, 3'b000} +: 8] = 8'h80;
                buf_d[14]  = '0;
                buf_d[15]  = {23'd0, byte_cnt_q, 3'd0};
                hold_d     = '0;
                word_idx_d = '0;
                msg_d      = buf_d[0];
                state_d    = S_EMIT;
            end
            S_EMIT: begin
                if (hold_q == 4'(HOLD_CYCLES - 1)) begin
                    hold_d = '0;
                    if (word_idx_q == 4'd15) begin
                        state_d = S_WAIT;
                        seen_d  = 1'b0;
                    end else begin
                        word_idx_d = word_idx_q + 4'd1;
                        msg_d      = buf_q[word_idx_q + 4'd1];
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            S_WAIT: begin
                // Release only on a high-then-low sequence seen while waiting.
                if (core_dv_flag) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    seen_d     = 1'b0;
                    state_d    = S_COLLECT;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    msg_d      = '0;
                    clear_buf  = 1'b1;
                end
            end
            default: state_d = S_COLLECT;
        endcase

        if (clear_buf) begin
            for (int i = 0; i < 16; i++) buf_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_COLLECT;
            byte_cnt_q <= '0;
            hold_q     <= '0;
            word_idx_q <= '0;
            msg_q      <= '0;
            seen_q     <= 1'b0;
            for (int i = 0; i < 16; i++) buf_q[i] <= '0;
`ifdef SHA256_PACKER_LEN_CHECK_EN
            drop_q     <= 1'b0;
            len_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            hold_q     <= hold_d;
            word_idx_q <= word_idx_d;
            msg_q      <= msg_d;
            seen_q     <= seen_d;
            for (int i = 0; i < 16; i++) buf_q[i] <= buf_d[i];
`ifdef SHA256_PACKER_LEN_CHECK_EN
            drop_q     <= drop_d;
            len_err_q  <= len_err_d;
`endif
        end
    end

    assign MP_dv       = (state_q == S_EMIT);
    assign busy        = (state_q != S_COLLECT);
    assign counter     = {1'b0, word_idx_q};
    assign message_out = msg_q;
`ifdef SHA256_PACKER_LEN_CHECK_EN
    assign len_err     = len_err_q;
`else
    assign len_err     = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_msg_packer.sv
// Scoreboard bench for sha256_msg_packer: expected padded words are queued per message and
// compared word by word as the burst is emitted.
module tb_sha256_msg_packer;

    localparam int HOLD = 3;
`ifdef SHA256_PACKER_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_last = 1'b0;
    logic        core_dv_flag = 1'b0;
    logic        MP_dv;
    logic [31:0] message_out;
    logic [4:0]  counter;
    logic        busy;
    logic        len_err;

    int          total_cnt = 0;
    int          pass_cnt = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  pay [0:63];

    sha256_msg_packer #(.HOLD_CYCLES(HOLD), .MAX_BYTES(55)) dut (
        .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_byte(rx_byte), .rx_last(rx_last),
        .core_dv_flag(core_dv_flag), .MP_dv(MP_dv), .message_out(message_out),
        .counter(counter), .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference padding: message bytes, 0x80, zeros, 64-bit big-endian bit length.
    task automatic push_expect(input int len);
        logic [7:0] m [0:63];
        int n;
        n = (len > 55) ? 55 : len;
        for (int i = 0; i < 64; i++) m[i] = 8'h00;
        for (int i = 0; i < n; i++) m[i] = pay[i];
        m[n]  = 8'h80;
        m[62] = 8'((n * 8) >> 8);
        m[63] = 8'((n * 8) & 255);
        for (int k = 0; k < 16; k++) exp_q.push_back({m[4*k], m[4*k+1], m[4*k+2], m[4*k+3]});
    endtask

    task automatic set_abc();
        pay[0] = 8'h61; pay[1] = 8'h62; pay[2] = 8'h63;
    endtask

    task automatic send_msg(input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            rx_dv = 1'b1; rx_byte = pay[i]; rx_last = (i == len - 1);
        end
        @(negedge clk);
        rx_dv = 1'b0; rx_last = 1'b0;
    endtask

    // Called at the negedge one cycle after the rx_last byte was accepted.
    task automatic collect_burst(input bit junk_rx, input bit flag_pulse);
        logic [31:0] cur;
        int k;
        cur = 32'hDEAD_BEEF;
        total_cnt++;
        if (busy !== 1'b1 || MP_dv !== 1'b0) $display("FAIL pad_cycle: busy=%b MP_dv=%b required busy=1 MP_dv=0", busy, MP_dv);
        else pass_cnt++;
        @(negedge clk);
        for (int cyc = 0; cyc < 16 * HOLD; cyc++) begin
            k = cyc / HOLD;
            if (cyc % HOLD == 0) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL scoreboard_empty: word %0d has no expected value", k);
                else begin pass_cnt++; cur = exp_q.pop_front(); end
            end
            total_cnt++;
            if (MP_dv !== 1'b1) $display("FAIL burst_mp_dv: cycle %0d MP_dv=%b required 1", cyc, MP_dv);
            else pass_cnt++;
            total_cnt++;
            if (counter !== 5'(k)) $display("FAIL burst_counter: cycle %0d counter=%0d required %0d", cyc, counter, k);
            else pass_cnt++;
            total_cnt++;
            if (message_out !== cur) $display("FAIL burst_word: cycle %0d word %0d got %h required %h", cyc, k, message_out, cur);
            else pass_cnt++;
            if (junk_rx && (cyc % 7 == 3)) begin
                rx_dv = 1'b1; rx_byte = 8'hEE; rx_last = cyc[0];
            end else begin
                rx_dv = 1'b0; rx_last = 1'b0;
            end
            core_dv_flag = flag_pulse && (cyc >= 10) && (cyc < 12);
            @(negedge clk);
        end
        rx_dv = 1'b0; rx_last = 1'b0;
        total_cnt++;
        if (MP_dv !== 1'b0 || counter !== 5'd15 || message_out !== cur || busy !== 1'b1)
            $display("FAIL wait_entry: MP_dv=%b counter=%0d word=%h busy=%b required 0/15/%h/1",
                     MP_dv, counter, message_out, busy, cur);
        else pass_cnt++;
    endtask

    task automatic release_core(input bit junk_on_return);
        for (int i = 0; i < 4; i++) begin
            if (junk_on_return) begin rx_dv = 1'b1; rx_byte = 8'hEE; end
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL wait_hold: busy=%b required 1 before core_dv_flag", busy);
            else pass_cnt++;
            @(negedge clk);
        end
        rx_dv = 1'b0;
        core_dv_flag = 1'b1;
        repeat (32) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || counter !== 5'd15) $display("FAIL wait_flag_high: busy=%b counter=%0d required 1/15", busy, counter);
        else pass_cnt++;
        core_dv_flag = 1'b0;
        if (junk_on_return) begin rx_dv = 1'b1; rx_byte = 8'hEE; rx_last = 1'b0; end
        @(negedge clk);
        rx_dv = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || counter !== 5'd0 || message_out !== 32'h0 || MP_dv !== 1'b0)
            $display("FAIL release: busy=%b counter=%0d word=%h MP_dv=%b required 0/0/0/0", busy, counter, message_out, MP_dv);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++;
        if (MP_dv !== 1'b0 || message_out !== 32'h0 || counter !== 5'd0 || busy !== 1'b0 || len_err !== 1'b0)
            $display("FAIL reset_state: MP_dv=%b word=%h counter=%0d busy=%b len_err=%b required all 0",
                     MP_dv, message_out, counter, busy, len_err);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || MP_dv !== 1'b0) $display("FAIL reset_release: busy=%b MP_dv=%b required 0/0", busy, MP_dv);
        else pass_cnt++;
    endtask

    task automatic test_abc(input bit junk, input bit pulse);
        set_abc();
        push_expect(3);
        send_msg(3);
        collect_burst(junk, pulse);
        release_core(junk);
    endtask

    task automatic test_max55();
        for (int i = 0; i < 55; i++) pay[i] = 8'h41;
        push_expect(55);
        send_msg(55);
        collect_burst(1'b0, 1'b0);
        release_core(1'b0);
    endtask

    task automatic test_overflow();
        logic exp_err;
        for (int i = 0; i < 58; i++) pay[i] = 8'h41;
        if (!LEN_CHECK) push_expect(58);
        for (int i = 0; i < 58; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_err = LEN_CHECK && (i - 1 == 55);
                total_cnt++;
                if (len_err !== exp_err) $display("FAIL len_err_pulse: after byte %0d len_err=%b required %b", i - 1, len_err, exp_err);
                else pass_cnt++;
            end
            rx_dv = 1'b1; rx_byte = pay[i]; rx_last = (i == 57);
        end
        @(negedge clk);
        rx_dv = 1'b0; rx_last = 1'b0;
        total_cnt++;
        if (len_err !== 1'b0) $display("FAIL len_err_single: len_err=%b required 0 after final byte", len_err);
        else pass_cnt++;
        if (LEN_CHECK) begin
            for (int i = 0; i < 6; i++) begin
                total_cnt++;
                if (MP_dv !== 1'b0 || busy !== 1'b0) $display("FAIL overflow_idle: MP_dv=%b busy=%b required 0/0", MP_dv, busy);
                else pass_cnt++;
                @(negedge clk);
            end
        end else begin
            collect_burst(1'b0, 1'b0);
            release_core(1'b0);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        set_abc();
        push_expect(3);
        send_msg(3);
        for (int i = 0; i < 60 && !found; i++) begin
            if (MP_dv === 1'b1 && counter === 5'd7) found = 1'b1;
            else @(negedge clk);
        end
        total_cnt++;
        if (!found) $display("FAIL reset_mid_reach: counter=%0d MP_dv=%b never reached counter 7", counter, MP_dv);
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (MP_dv !== 1'b0 || counter !== 5'd0 || busy !== 1'b0 || message_out !== 32'h0)
            $display("FAIL reset_mid: MP_dv=%b counter=%0d busy=%b word=%h required 0/0/0/0", MP_dv, counter, busy, message_out);
        else pass_cnt++;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_abc(1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) pay[i] = 8'h00;
        test_reset();
        test_abc(1'b1, 1'b1);
        test_abc(1'b0, 1'b0);
        test_max55();
        test_overflow();
        test_abc(1'b0, 1'b0);
        test_reset_mid();
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: %0d words remain, required 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
